turbosim_host_ctrl: RTL and testbench

Sequencer placed between a host record stream and the `turbosim` accelerator.
- Loads one batch of 32-bit input-change records into the turbosim input FIFO, honouring `full`.
- Pulses `go`, waits for the `done` drop and rise, and measures solve length in clock cycles.
- Forwards turbosim output-change records to a result stream while the solve runs.

---
 rtl/turbosim_host_ctrl.sv | 165 ++++++++++++++++
 tb/tb_turbosim_host_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/turbosim_host_ctrl.sv
// turbosim_host_ctrl
//   Sequencer between a host record stream and the turbosim accelerator.
//   Loads one batch of 32-bit input-change records into the turbosim input
//   FIFO, pulses go, waits for done to drop and rise, measures the solve
//   length and forwards turbosim output records to a result stream.
//
// Configuration macro: TS_CTRL_STATS_EN
//   defined   : cycle_count / iter_count counters are built
//   undefined : cycle_count / iter_count tied to 0
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   h_valid/h_ready/h_record/h_last   host record stream (input)
//   ts_wr/ts_in_record/ts_full        turbosim input FIFO write side
//   ts_go/ts_done                     turbosim start / idle handshake
//   ts_rd/ts_empty/ts_out_record      turbosim output FIFO read side
//   r_valid/r_ready/r_record          result stream (output)
//   busy, err, cycle_count, iter_count  status
module turbosim_host_ctrl #(
  parameter int unsigned GO_ACK_CYC    = 4,
  parameter int unsigned SOLVE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [31:0] h_record,
  input  logic        h_last,
  output logic        ts_wr,
  output logic [31:0] ts_in_record,
  input  logic        ts_full,
  output logic        ts_go,
  input  logic        ts_done,
  output logic        ts_rd,
  input  logic        ts_empty,
  input  logic [31:0] ts_out_record,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_record,
  output logic        busy,
  output logic        err,
  output logic [15:0] cycle_count,
  output logic [15:0] iter_count
);

  localparam int unsigned ACK_W = (GO_ACK_CYC > 1)    ? $clog2(GO_ACK_CYC)    : 1;
  localparam int unsigned TO_W  = (SOLVE_TIMEOUT > 1) ? $clog2(SOLVE_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GO, S_ACK, S_SOLVE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_armed;
  logic [ACK_W-1:0]   r_ack_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_err;
  logic               w_h_ready;
  logic               w_go;
  logic               w_busy;
  logic               w_timeout;
  logic               w_ack_last;
  logic               w_to_last;

  assign w_ack_last = (r_ack_cnt == ACK_W'(GO_ACK_CYC - 1));
  assign w_to_last  = (r_to_cnt  == TO_W'(SOLVE_TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    w_h_ready = 1'b0;
    w_go      = 1'b0;
    w_busy    = 1'b1;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        // r_armed keeps h_ready low in the cycle right after reset release
        w_h_ready = r_armed;
        if (h_valid && r_armed) w_next = h_last ? S_GO : S_LOAD;
      end
      S_LOAD: begin
        w_h_ready = !ts_full;
        if (h_valid && !ts_full && h_last) w_next = S_GO;
      end
      S_GO: begin
        w_go   = 1'b1;
        w_next = S_ACK;
      end
      S_ACK: begin
        // done never dropping means there was no work: treat as solved
        if (!ts_done)        w_next = S_SOLVE;
        else if (w_ack_last) w_next = S_IDLE;
      end
      S_SOLVE: begin
        if (ts_done) begin
          w_next = S_IDLE;
        end else if (w_to_last) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_ack_cnt <= '0;
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      if (r_state == S_GO)       r_ack_cnt <= '0;
      else if (r_state == S_ACK) r_ack_cnt <= r_ack_cnt + 1'b1;
      if (r_state == S_ACK)        r_to_cnt <= '0;
      else if (r_state == S_SOLVE) r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign h_ready      = w_h_ready;
  assign ts_wr        = h_valid & w_h_ready;
  assign ts_in_record = ts_wr ? h_record : '0;
  assign ts_go        = w_go;
  assign busy         = w_busy;
  assign err          = r_err;

  assign r_valid  = !ts_empty;
  assign r_record = ts_out_record;
  assign ts_rd    = r_valid & r_ready;

`ifdef TS_CTRL_STATS_EN
  logic [15:0] r_cycle_cnt;
  logic [15:0] r_iter_cnt;
  logic        w_complete;

  assign w_complete = ts_done &&
                      ((r_state == S_SOLVE) || ((r_state == S_ACK) && w_ack_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_iter_cnt  <= '0;
    end else begin
      if (r_state == S_GO)
        r_cycle_cnt <= '0;
      else if (((r_state == S_ACK) || (r_state == S_SOLVE)) && (r_cycle_cnt != '1))
        r_cycle_cnt <= r_cycle_cnt + 16'd1;
      if (w_complete) r_iter_cnt <= r_iter_cnt + 16'd1;
    end
  end

  assign cycle_count = r_cycle_cnt;
  assign iter_count  = r_iter_cnt;
`else
  assign cycle_count = '0;
  assign iter_count  = '0;
`endif

endmodule

// File: tb/tb_turbosim_host_ctrl.sv
// Directed bench for turbosim_host_ctrl. Inputs change on the falling edge,
// outputs are checked 1 ns later; the DUT updates on the rising edge.
module tb_turbosim_host_ctrl;

`ifdef TS_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        h_valid, h_last, ts_full, ts_done, ts_empty, r_ready;
  logic [31:0] h_record, ts_out_record;
  logic        h_ready, ts_wr, ts_go, ts_rd, r_valid, busy, err;
  logic [31:0] ts_in_record, r_record;
  logic [15:0] cycle_count, iter_count;

  // second instance, short timeout, own handshake inputs
  logic        t_h_valid, t_h_last, t_done;
  logic        t_h_ready, t_wr, t_go, t_rd, t_rvalid, t_busy, t_err;
  logic [31:0] t_in_rec, t_rrec;
  logic [15:0] t_cyc, t_iter;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ts_wr) wr_cnt++;
    if (ts_rd) rd_cnt++;
  end

  turbosim_host_ctrl #(.GO_ACK_CYC(4), .SOLVE_TIMEOUT(65535)) dut (
    .clk(clk), .rst(rst),
    .h_valid(h_valid), .h_ready(h_ready), .h_record(h_record), .h_last(h_last),
    .ts_wr(ts_wr), .ts_in_record(ts_in_record), .ts_full(ts_full),
    .ts_go(ts_go), .ts_done(ts_done),
    .ts_rd(ts_rd), .ts_empty(ts_empty), .ts_out_record(ts_out_record),
    .r_valid(r_valid), .r_ready(r_ready), .r_record(r_record),
    .busy(busy), .err(err), .cycle_count(cycle_count), .iter_count(iter_count)
  );

  turbosim_host_ctrl #(.GO_ACK_CYC(4), .SOLVE_TIMEOUT(10)) dut_to (
    .clk(clk), .rst(rst),
    .h_valid(t_h_valid), .h_ready(t_h_ready), .h_record(h_record), .h_last(t_h_last),
    .ts_wr(t_wr), .ts_in_record(t_in_rec), .ts_full(ts_full),
    .ts_go(t_go), .ts_done(t_done),
    .ts_rd(t_rd), .ts_empty(ts_empty), .ts_out_record(ts_out_record),
    .r_valid(t_rvalid), .r_ready(r_ready), .r_record(t_rrec),
    .busy(t_busy), .err(t_err), .cycle_count(t_cyc), .iter_count(t_iter)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  logic [31:0] fifo [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; h_valid = 0; h_last = 0; h_record = '0; ts_full = 0;
    ts_done = 1; ts_empty = 1; ts_out_record = '0; r_ready = 0;
    t_h_valid = 0; t_h_last = 0; t_done = 0;
    fifo[0] = 32'h1111_0001; fifo[1] = 32'h2222_0002;
    fifo[2] = 32'h3333_0003; fifo[3] = 32'h4444_0004;

    // ---- reset state
    tick; tick; #1;
    chk("rst_h_ready", h_ready, 0);
    chk("rst_ts_wr", ts_wr, 0);
    chk("rst_ts_go", ts_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cyc", cycle_count, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_r_valid", r_valid, 0);
    tick; rst = 0; #1;
    chk("rel_h_ready_low", h_ready, 0);
    tick; #1;
    chk("idle_h_ready", h_ready, 1);

    // ---- batch 1: 3 records, 1 ACK + 20 SOLVE cycles
    h_valid = 1; h_record = 32'h4001_0010; h_last = 0; #1;
    chk("b1_wr0", ts_wr, 1);
    chk("b1_dat0", ts_in_record, 32'h4001_0010);
    tick; h_record = 32'h8002_0020; #1;
    chk("b1_wr1", ts_wr, 1);
    chk("b1_dat1", ts_in_record, 32'h8002_0020);
    chk("b1_busy", busy, 1);
    tick; h_record = 32'hC003_0030; h_last = 1; #1;
    chk("b1_wr2", ts_wr, 1);
    chk("b1_dat2", ts_in_record, 32'hC003_0030);
    tick; h_valid = 0; h_last = 0; #1;
    chk("b1_go", ts_go, 1);
    chk("b1_go_h_ready", h_ready, 0);
    chk("b1_go_nowr", ts_wr, 0);
    tick; ts_done = 0; #1;
    chk("b1_ack_go_low", ts_go, 0);
    chk("b1_ack_busy", busy, 1);
    repeat (19) tick;
    #1 chk("b1_solve_busy", busy, 1);
    ts_done = 1;
    tick; #1;
    chk("b1_done_busy", busy, 0);
    chk("b1_cyc", cycle_count, STATS ? 21 : 0);
    chk("b1_iter", iter_count, STATS ? 1 : 0);
    chk("b1_err", err, 0);
    chk("b1_wrcnt", wr_cnt, 3);

    // ---- batch 2: ts_full held 5 cycles mid-batch, done never drops
    h_valid = 1; h_record = 32'h0004_0040; #1;
    chk("b2_wr0", ts_wr, 1);
    tick; h_record = 32'h4005_0050; ts_full = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("b2_full_h_ready", h_ready, 0);
      chk("b2_full_nowr", ts_wr, 0);
      tick;
    end
    ts_full = 0; #1;
    chk("b2_wr1", ts_wr, 1);
    chk("b2_dat1", ts_in_record, 32'h4005_0050);
    tick; h_record = 32'h8006_0060; h_last = 1; #1;
    chk("b2_wr2", ts_wr, 1);
    tick; h_valid = 0; h_last = 0; #1;
    chk("b2_go", ts_go, 1);
    for (int i = 0; i < 4; i++) begin
      tick; #1;
      chk("b2_ack_busy", busy, 1);
    end
    tick; #1;
    chk("b2_ack_exit", busy, 0);
    chk("b2_err", err, 0);
    chk("b2_cyc", cycle_count, STATS ? 4 : 0);
    chk("b2_iter", iter_count, STATS ? 2 : 0);
    chk("b2_wrcnt", wr_cnt, 6);

    // ---- timeout instance: done stuck low, SOLVE_TIMEOUT = 10
    t_h_valid = 1; t_h_last = 1; h_record = 32'h0007_0070; #1;
    chk("to_wr", t_wr, 1);
    chk("to_dat", t_in_rec, 32'h0007_0070);
    tick; t_h_valid = 0; t_h_last = 0; #1;
    chk("to_go", t_go, 1);
    tick;
    for (int i = 0; i < 10; i++) begin
      tick; #1;
      chk("to_solve_busy", t_busy, 1);
      chk("to_solve_err", t_err, 0);
    end
    tick; #1;
    chk("to_busy", t_busy, 0);
    chk("to_err", t_err, 1);
    chk("to_iter", t_iter, 0);
    chk("to_cyc", t_cyc, STATS ? 11 : 0);
    tick; #1;
    chk("to_err_sticky", t_err, 1);

    // ---- result path: 4 records, r_ready every other cycle
    begin
      int idx = 0;
      logic exp_rd;
      for (int c = 0; c < 10; c++) begin
        tick;
        r_ready = (c % 2 == 0);
        ts_empty = (idx >= 4);
        ts_out_record = (idx < 4) ? fifo[idx] : '0;
        #1;
        exp_rd = r_ready && (idx < 4);
        chk("res_valid", r_valid, (idx < 4));
        chk("res_rd", ts_rd, exp_rd);
        if (idx < 4) chk("res_rec", r_record, fifo[idx]);
        if (exp_rd) idx++;
      end
      tick; r_ready = 0; ts_empty = 1; #1;
      chk("res_rdcnt", rd_cnt, 4);
    end

    // ---- reset in LOAD after 2 records, then a 1-record batch
    h_valid = 1; h_record = 32'h000A_00A0; h_last = 0; #1;
    chk("rs_wr0", ts_wr, 1);
    tick; h_record = 32'h000B_00B0; #1;
    chk("rs_wr1", ts_wr, 1);
    tick; h_record = 32'h000C_00C0; #1;
    chk("rs_wr2_pre", ts_wr, 1);
    rst = 1; #1;
    chk("rs_async_wr", ts_wr, 0);
    chk("rs_h_ready", h_ready, 0);
    chk("rs_busy", busy, 0);
    chk("rs_go", ts_go, 0);
    chk("rs_cyc", cycle_count, 0);
    chk("rs_iter", iter_count, 0);
    chk("rs_err_to", t_err, 0);
    tick; h_valid = 0; rst = 0;
    tick; h_valid = 1; h_last = 1; h_record = 32'h000D_00D0; #1;
    chk("rs_nb_wr", ts_wr, 1);
    chk("rs_nb_dat", ts_in_record, 32'h000D_00D0);
    tick; h_valid = 0; h_last = 0; #1;
    chk("rs_nb_go", ts_go, 1);
    tick; ts_done = 0;
    tick; ts_done = 1;
    tick; #1;
    chk("rs_nb_busy", busy, 0);
    chk("rs_nb_iter", iter_count, STATS ? 1 : 0);
    chk("rs_nb_cyc", cycle_count, STATS ? 2 : 0);
    chk("rs_nb_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
